// File: rtl/config_frame_writer.sv
// Configuration stream writer for one tile's connection block: filters frames by
// tile ID, assembles the payload in a shadow register and commits it to c with a cset strobe.
module config_frame_writer #(
    parameter int W          = 16,
    parameter int DATAIN     = 8,
    parameter int DATAOUT    = 16,
    parameter int CONF_WIDTH = W * (DATAIN + DATAOUT),
    parameter int IW         = 32,
    parameter int NWORDS     = (CONF_WIDTH + IW - 1) / IW,
    parameter int ID_W       = 8,
    parameter int TILE_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [IW-1:0]         cfg_data,
    input  logic                  cfg_last,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_HDR, S_LOAD, S_SKIP, S_COMMIT} state_t;

    localparam int                CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NWORDS - 1);
    localparam logic [ID_W-1:0]   MY_ID    = ID_W'(TILE_ID);
    localparam int                PAD_W    = NWORDS * IW;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CONF_WIDTH-1:0]   shadow_q, shadow_d;
    logic [CONF_WIDTH-1:0]   c_q, c_d;
    logic                    cset_q, cset_d;
    logic                    err_q, err_d;
    logic                    xfer;
    logic                    id_hit;
    logic [PAD_W-1:0]        pad;

    assign cfg_ready = (state_q != S_COMMIT);
    assign xfer      = cfg_valid && cfg_ready;
    assign id_hit    = (cfg_data[ID_W-1:0] == MY_ID) || (&cfg_data[ID_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HDR;
            cnt_q    <= '0;
            shadow_q <= '0;
            c_q      <= '0;
            cset_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            c_q      <= c_d;
            cset_q   <= cset_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        c_d      = c_q;
        // Padded view lets the last word carry bits past CONF_WIDTH that are then dropped.
        pad                  = '0;
        pad[CONF_WIDTH-1:0]  = shadow_q;
        pad[cnt_q*IW +: IW]  = cfg_data;
        case (state_q)
            S_HDR: begin
                if (xfer && !cfg_last) begin
                    if (id_hit) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    shadow_d = pad[CONF_WIDTH-1:0];
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = cfg_last ? S_COMMIT : S_SKIP;
                    end else if (cfg_last) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_SKIP: begin
                if (xfer && cfg_last) begin
                    state_d = S_HDR;
                end
            end
            S_COMMIT: begin
                state_d = S_HDR;
                c_d     = shadow_q;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_comb begin
        cset_d = (state_q == S_COMMIT);
        err_d  = 1'b0;
        if (xfer) begin
            case (state_q)
                S_HDR:   err_d = cfg_last;
                S_LOAD:  err_d = (cnt_q == LAST_CNT) ? !cfg_last : cfg_last;
                default: err_d = 1'b0;
            endcase
        end
    end

    assign c    = c_q;
    assign cset = cset_q;
    assign done = cset_q;
    assign err  = err_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: table-driven frames, timing sequences
// for commit/error/reset corners, and random frames against a frame-level model.
module tb_config_frame_writer;

    localparam int CW = 384;
    localparam int NW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [31:0]   cfg_data;
    logic          cfg_last;
    logic [CW-1:0] c;
    logic          cset;
    logic          done;
    logic          err;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_cset  = 0;
    int            n_err   = 0;
    logic [CW-1:0] exp_c   = '0;

    typedef struct {
        logic [31:0] hdr;
        int          n;
        logic [31:0] base;
        int          exp_cs;
        int          exp_er;
    } vec_t;

    vec_t vt[9];

    always #5 clk = ~clk;

    config_frame_writer #(.TILE_ID(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .c         (c),
        .cset      (cset),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cset) n_cset++;
            if (err)  n_err++;
            chk("cset_err_exclusive", CW'(cset & err), '0);
            chk("done_tracks_cset", CW'(done), CW'(cset));
        end
    end

    function automatic logic [CW-1:0] payload(input logic [31:0] base);
        logic [CW-1:0] v;
        for (int k = 0; k < NW; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    // Frame-level reference: outcome follows from header ID and where cfg_last falls.
    function automatic void model_frame(input logic [31:0] hdr, input int n, input logic [31:0] base,
                                        output int ecs, output int eer);
        ecs = 0;
        eer = 0;
        if (n == 0) begin
            eer = 1;
        end else if (hdr[7:0] == 8'h03 || hdr[7:0] == 8'hFF) begin
            if (n == NW) begin
                ecs   = 1;
                exp_c = payload(base);
            end else begin
                eer = 1;
            end
        end
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input int gap);
        logic rdy;
        int   b;
        logic ok;
        cfg_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        b  = 0;
        ok = 1'b0;
        while (!ok && b <= 40) begin
            @(negedge clk);
            rdy = cfg_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
            else b++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: cfg_ready stayed %0b, required 1", rdy);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int n, input logic [31:0] base, input int maxgap);
        send_word(hdr, n == 0, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        for (int k = 0; k < n; k++)
            send_word(base + 32'(k), k == n - 1, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic settle_and_check(input string nm, input int cs0, input int er0,
                                    input int ecs, input int eer);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_cset_count"}, CW'(n_cset - cs0), CW'(ecs));
        chk({nm, "_err_count"},  CW'(n_err - er0),  CW'(eer));
        chk({nm, "_c"}, c, exp_c);
    endtask

    task automatic run_model_frame(input string nm, input logic [31:0] hdr, input int n,
                                   input logic [31:0] base, input int maxgap);
        int cs0, er0, ecs, eer;
        cs0 = n_cset;
        er0 = n_err;
        send_frame(hdr, n, base, maxgap);
        model_frame(hdr, n, base, ecs, eer);
        settle_and_check(nm, cs0, er0, ecs, eer);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs0, er0;
        vt[0] = '{32'h0000_0003, 12, 32'hA500_0000, 1, 0};
        vt[1] = '{32'h0000_0007, 12, 32'h1100_0000, 0, 0};
        vt[2] = '{32'h0000_00FF, 12, 32'hB600_0000, 1, 0};
        vt[3] = '{32'h0000_0003,  5, 32'hC700_0000, 0, 1};
        vt[4] = '{32'h0000_0003, 14, 32'hD800_0000, 0, 1};
        vt[5] = '{32'h1234_5603,  0, 32'h0000_0000, 0, 1};
        vt[6] = '{32'hABCD_EF03, 12, 32'hE900_0000, 1, 0};
        vt[7] = '{32'h0000_0013,  3, 32'h2200_0000, 0, 0};
        vt[8] = '{32'h0000_00FE, 12, 32'h3300_0000, 0, 0};

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_c", c, '0);
        chk("reset_cset", CW'(cset), '0);
        chk("reset_done", CW'(done), '0);
        chk("reset_err", CW'(err), '0);
        chk("reset_ready", CW'(cfg_ready), CW'(1));
        @(posedge clk);
        #1;

        // Full frame with exact commit timing.
        cs0 = n_cset;
        er0 = n_err;
        send_word(32'h0000_0003, 1'b0, 0);
        for (int k = 0; k < NW; k++) send_word(32'hA500_0000 + 32'(k), k == NW - 1, 0);
        @(negedge clk);
        chk("commit_ready_low", CW'(cfg_ready), '0);
        chk("commit_cset_not_yet", CW'(cset), '0);
        @(negedge clk);
        chk("commit_cset_high", CW'(cset), CW'(1));
        chk("commit_done_high", CW'(done), CW'(1));
        chk("commit_c", c, payload(32'hA500_0000));
        chk("commit_ready_back", CW'(cfg_ready), CW'(1));
        @(negedge clk);
        chk("commit_cset_one_cycle", CW'(cset), '0);
        exp_c = payload(32'hA500_0000);
        chk("commit_err_count", CW'(n_err - er0), '0);
        chk("commit_cset_count", CW'(n_cset - cs0), CW'(1));
        @(posedge clk);
        #1;

        // Table-driven frames: expectations written by hand per record.
        foreach (vt[i]) begin
            cs0 = n_cset;
            er0 = n_err;
            send_frame(vt[i].hdr, vt[i].n, vt[i].base, 0);
            if (vt[i].exp_cs != 0) exp_c = payload(vt[i].base);
            settle_and_check($sformatf("vec%0d", i), cs0, er0, vt[i].exp_cs, vt[i].exp_er);
        end

        // Missing last: err appears right after word 11 is accepted.
        cs0 = n_cset;
        er0 = n_err;
        send_word(32'h0000_0003, 1'b0, 0);
        for (int k = 0; k < NW; k++) send_word(32'h4400_0000 + 32'(k), 1'b0, 0);
        @(negedge clk);
        chk("missing_last_err_pulse", CW'(err), CW'(1));
        @(negedge clk);
        chk("missing_last_err_one_cycle", CW'(err), '0);
        @(posedge clk);
        #1;
        send_word(32'h4400_000C, 1'b0, 0);
        send_word(32'h4400_000D, 1'b1, 0);
        settle_and_check("missing_last", cs0, er0, 0, 1);
        run_model_frame("after_missing_last", 32'h0000_0003, NW, 32'h4500_0000, 0);

        // Back-to-back frames, second one with valid gaps.
        cs0 = n_cset;
        er0 = n_err;
        send_frame(32'h0000_0003, NW, 32'h5100_0000, 0);
        send_frame(32'h0000_00FF, NW, 32'h5200_0000, 3);
        exp_c = payload(32'h5200_0000);
        settle_and_check("back_to_back", cs0, er0, 2, 0);

        // Asynchronous reset in the middle of a payload.
        run_model_frame("pre_reset_commit", 32'h0000_0003, NW, 32'h5A00_0000, 0);
        send_word(32'h0000_0003, 1'b0, 0);
        for (int k = 0; k < 6; k++) send_word(32'h6600_0000 + 32'(k), 1'b0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_c", c, '0);
        chk("async_reset_cset", CW'(cset), '0);
        chk("async_reset_ready", CW'(cfg_ready), CW'(1));
        exp_c = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_model_frame("post_reset_frame", 32'h0000_0003, NW, 32'h6B00_0000, 0);

        // Random frames checked against the frame-level model.
        for (int t = 0; t < 30; t++) begin
            logic [31:0] hdr;
            logic [7:0]  id;
            int          sel, n;
            sel = int'($urandom_range(3, 0));
            if (sel == 1) id = 8'hFF;
            else if (sel == 2) begin
                id = 8'($urandom);
                if (id == 8'h03 || id == 8'hFF) id = 8'h42;
            end else id = 8'h03;
            hdr = {24'($urandom), id};
            n   = ($urandom_range(9, 0) < 6) ? NW : int'($urandom_range(15, 0));
            run_model_frame($sformatf("rand%0d", t), hdr, n, $urandom, int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
